// File: rtl/axi_stream_loopback_delay.sv
// Frame-aware multi-channel AXI Stream loopback with a fixed-latency return path.
// Optional single-shot tdata[0] corruption is built when AXIS_LOOPBACK_ERR_INJECT_EN is defined.
module axi_stream_loopback_delay #(
  parameter int unsigned NCHAN       = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NCHAN-1:0]              close_loop,
  input  logic [NCHAN*DATA_WIDTH-1:0]   tx_tdata,
  input  logic [NCHAN-1:0]              tx_tlast,
  input  logic [NCHAN-1:0]              tx_tvalid,
`ifdef AXIS_LOOPBACK_ERR_INJECT_EN
  input  logic [NCHAN-1:0]              inject_err,
`endif
  output logic [NCHAN*DATA_WIDTH-1:0]   rx_tdata,
  output logic [NCHAN-1:0]              rx_tlast,
  output logic [NCHAN-1:0]              rx_tvalid,
  output logic [2*NCHAN-1:0]            loop_state,
  output logic [NCHAN*COUNT_WIDTH-1:0]  frames_out
);

  typedef enum logic [1:0] {
    StOpen     = 2'd0,
    StClosed   = 2'd1,
    StDraining = 2'd2
  } loop_state_e;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    logic [DATA_WIDTH-1:0]  tdata;
    logic [DATA_WIDTH-1:0]  beat_data;
    loop_state_e            state_q, state_d;
    logic                   in_frame_q, in_frame_d;
    logic                   pass;
    logic [LATENCY-1:0]     vld_q;
    logic [LATENCY-1:0]     last_q;
    logic [DATA_WIDTH-1:0]  data_q [LATENCY];
    logic [COUNT_WIDTH-1:0] frames_q;

    assign tdata = tx_tdata[i*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q    <= StOpen;
        in_frame_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        in_frame_q <= in_frame_d;
      end
    end

    // Frame tracking follows every TX beat, passed or discarded, so loop switching
    // always lands on a real frame boundary.
    always_comb begin
      in_frame_d = in_frame_q;
      if (tx_tvalid[i]) in_frame_d = ~tx_tlast[i];
      state_d = state_q;
      unique case (state_q)
        StOpen: begin
          if (close_loop[i] && !in_frame_q) state_d = StClosed;
        end
        StClosed: begin
          if (!close_loop[i]) state_d = in_frame_d ? StDraining : StOpen;
        end
        StDraining: begin
          if (close_loop[i])                     state_d = StClosed;
          else if (tx_tvalid[i] && tx_tlast[i])  state_d = StOpen;
        end
        default: state_d = StOpen;
      endcase
    end

    always_comb begin
      pass = 1'b0;
      unique case (state_q)
        StOpen:               pass = tx_tvalid[i] & close_loop[i] & ~in_frame_q;
        StClosed, StDraining: pass = tx_tvalid[i];
        default:              pass = 1'b0;
      endcase
    end

    assign loop_state[2*i +: 2] = state_q;

`ifdef AXIS_LOOPBACK_ERR_INJECT_EN
    logic pending_q;
    logic corrupt;

    // A pulse coinciding with a passed beat corrupts that beat without queueing another.
    assign corrupt = pass & (pending_q | inject_err[i]);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pending_q <= 1'b0;
      end else if (corrupt) begin
        pending_q <= 1'b0;
      end else if (inject_err[i]) begin
        pending_q <= 1'b1;
      end
    end

    assign beat_data = tdata ^ {{(DATA_WIDTH-1){1'b0}}, corrupt};
`else
    assign beat_data = tdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q  <= '0;
        last_q <= '0;
        for (int s = 0; s < LATENCY; s++) data_q[s] <= '0;
      end else begin
        vld_q[0]  <= pass;
        last_q[0] <= pass & tx_tlast[i];
        data_q[0] <= beat_data;
        for (int s = 1; s < LATENCY; s++) begin
          vld_q[s]  <= vld_q[s-1];
          last_q[s] <= last_q[s-1];
          data_q[s] <= data_q[s-1];
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        frames_q <= '0;
      end else if (vld_q[LATENCY-1] && last_q[LATENCY-1]) begin
        frames_q <= frames_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end

    assign rx_tvalid[i] = vld_q[LATENCY-1];
    assign rx_tlast[i]  = vld_q[LATENCY-1] & last_q[LATENCY-1];
    assign rx_tdata[i*DATA_WIDTH +: DATA_WIDTH] =
        vld_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
    assign frames_out[i*COUNT_WIDTH +: COUNT_WIDTH] = frames_q;
  end

endmodule

// File: tb/tb_axi_stream_loopback_delay.sv
// Bench for axi_stream_loopback_delay: vector table, directed corner sequences and a
// randomized phase, all checked against a cycle-level reference model.
module tb_axi_stream_loopback_delay;
  localparam int NCHAN = 2;
  localparam int DW    = 32;
  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int OPEN = 0, CLOSED = 1, DRAIN = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NCHAN-1:0]      close_loop, tx_tlast, tx_tvalid, rx_tlast, rx_tvalid;
  logic [NCHAN*DW-1:0]   tx_tdata, rx_tdata;
  logic [2*NCHAN-1:0]    loop_state;
  logic [NCHAN*CW-1:0]   frames_out;
`ifdef AXIS_LOOPBACK_ERR_INJECT_EN
  logic [NCHAN-1:0]      inject_err;
`endif

  always #5 clk = ~clk;

  axi_stream_loopback_delay #(
    .NCHAN(NCHAN), .DATA_WIDTH(DW), .LATENCY(LAT), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .close_loop(close_loop),
    .tx_tdata(tx_tdata),
    .tx_tlast(tx_tlast),
    .tx_tvalid(tx_tvalid),
`ifdef AXIS_LOOPBACK_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .rx_tdata(rx_tdata),
    .rx_tlast(rx_tlast),
    .rx_tvalid(rx_tvalid),
    .loop_state(loop_state),
    .frames_out(frames_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what went in LAT cycles ago comes out now.
  typedef struct packed {
    logic          v;
    logic          l;
    logic [DW-1:0] d;
  } beat_t;

  beat_t hist [NCHAN][LAT];
  int    ptr;
  int    m_state [NCHAN];
  bit    m_inf   [NCHAN];
  int    m_cnt   [NCHAN];
  bit    m_pend  [NCHAN];

  function automatic void model_reset();
    for (int ch = 0; ch < NCHAN; ch++) begin
      for (int k = 0; k < LAT; k++) hist[ch][k] = '0;
      m_state[ch] = OPEN;
      m_inf[ch]   = 1'b0;
      m_cnt[ch]   = 0;
      m_pend[ch]  = 1'b0;
    end
    ptr = 0;
  endfunction

  // Called at the negedge: compare, step the model with the current inputs, move to next cycle.
  task automatic advance();
    beat_t e, b;
    bit cl, tv, tl, pass, f_after, corrupt;
    for (int ch = 0; ch < NCHAN; ch++) begin
      e = hist[ch][ptr];
      chk($sformatf("rx_tvalid[%0d]", ch), 64'(rx_tvalid[ch]), 64'(e.v));
      chk($sformatf("rx_tlast[%0d]", ch), 64'(rx_tlast[ch]), 64'(e.l));
      chk($sformatf("rx_tdata[%0d]", ch), 64'(rx_tdata[ch*DW +: DW]), 64'(e.d));
      chk($sformatf("loop_state[%0d]", ch), 64'(loop_state[2*ch +: 2]), 64'(m_state[ch]));
      chk($sformatf("frames_out[%0d]", ch), 64'(frames_out[ch*CW +: CW]), 64'(m_cnt[ch]));
      cl = close_loop[ch];
      tv = tx_tvalid[ch];
      tl = tx_tlast[ch];
      pass = tv && ((m_state[ch] == OPEN) ? (cl && !m_inf[ch]) : 1'b1);
      corrupt = 1'b0;
`ifdef AXIS_LOOPBACK_ERR_INJECT_EN
      corrupt = pass && (m_pend[ch] || inject_err[ch]);
      if (corrupt) m_pend[ch] = 1'b0;
      else if (inject_err[ch]) m_pend[ch] = 1'b1;
`endif
      b = '0;
      if (pass) begin
        b.v = 1'b1;
        b.l = tl;
        b.d = tx_tdata[ch*DW +: DW] ^ {31'b0, corrupt};
      end
      hist[ch][ptr] = b;
      f_after = tv ? !tl : m_inf[ch];
      case (m_state[ch])
        OPEN:    if (cl && !m_inf[ch]) m_state[ch] = CLOSED;
        CLOSED:  if (!cl) m_state[ch] = f_after ? DRAIN : OPEN;
        default: if (cl) m_state[ch] = CLOSED;
                 else if (tv && tl) m_state[ch] = OPEN;
      endcase
      m_inf[ch] = f_after;
      if (e.v && e.l) m_cnt[ch] = (m_cnt[ch] + 1) % (1 << CW);
    end
    ptr = (ptr + 1) % LAT;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    advance();
  endtask

  task automatic drive(input int ch, input bit v, input bit l, input logic [DW-1:0] d);
    tx_tvalid[ch] = v;
    tx_tlast[ch]  = l;
    tx_tdata[ch*DW +: DW] = d;
  endtask

  task automatic idle();
    tx_tvalid = '0;
    tx_tlast  = '0;
    tx_tdata  = '0;
  endtask

  typedef struct {
    bit          cl;
    bit          tv;
    bit          tl;
    logic [31:0] d;
    bit          ev;
    bit          el;
    logic [31:0] ed;
    logic [1:0]  es;
    logic [3:0]  ef;
  } vec_t;

  vec_t vt [19];
  int   rem [NCHAN];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    close_loop = '0;
    idle();
`ifdef AXIS_LOOPBACK_ERR_INJECT_EN
    inject_err = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_tvalid", 64'(rx_tvalid), 64'(0));
    chk("reset rx_tlast", 64'(rx_tlast), 64'(0));
    chk("reset rx_tdata", 64'(rx_tdata), 64'(0));
    chk("reset loop_state", 64'(loop_state), 64'(0));
    chk("reset frames_out", 64'(frames_out), 64'(0));
    reset = 1'b0;

    // Closed from reset, 4-beat frame at cycle 10 returns at 10+LAT.
    for (int r = 0; r < 19; r++) begin
      vt[r] = '{cl: 1'b1, tv: 1'b0, tl: 1'b0, d: 32'h0, ev: 1'b0, el: 1'b0, ed: 32'h0,
                es: (r == 0) ? 2'd0 : 2'd1, ef: 4'd0};
      if (r >= 10 && r <= 13) begin
        vt[r].tv = 1'b1;
        vt[r].d  = 32'hA0 + 32'(r - 10);
        vt[r].tl = (r == 13);
      end
      if (r >= 14 && r <= 17) begin
        vt[r].ev = 1'b1;
        vt[r].ed = 32'hA0 + 32'(r - 14);
        vt[r].el = (r == 17);
      end
      if (r == 18) vt[r].ef = 4'd1;
    end
    for (int r = 0; r < 19; r++) begin
      close_loop = {1'b0, vt[r].cl};
      drive(0, vt[r].tv, vt[r].tl, vt[r].d);
      @(negedge clk);
      chk($sformatf("vec%0d rx_tvalid", r), 64'(rx_tvalid[0]), 64'(vt[r].ev));
      chk($sformatf("vec%0d rx_tlast", r), 64'(rx_tlast[0]), 64'(vt[r].el));
      chk($sformatf("vec%0d rx_tdata", r), 64'(rx_tdata[DW-1:0]), 64'(vt[r].ed));
      chk($sformatf("vec%0d loop_state", r), 64'(loop_state[1:0]), 64'(vt[r].es));
      chk($sformatf("vec%0d frames_out", r), 64'(frames_out[CW-1:0]), 64'(vt[r].ef));
      advance();
    end

    // Close request mid-frame waits for the frame end.
    close_loop[0] = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      close_loop[0] = (k >= 2);
      drive(0, 1'b1, k == 3, 32'hD0 + 32'(k));
      @(negedge clk);
      chk("midframe loop_state", 64'(loop_state[1:0]), 64'(OPEN));
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, k == 3, 32'hB0 + 32'(k));
      @(negedge clk);
      if (k == 0) chk("close at first beat", 64'(loop_state[1:0]), 64'(OPEN));
      if (k == 1) chk("closed after first beat", 64'(loop_state[1:0]), 64'(CLOSED));
      advance();
    end
    idle();
    repeat (LAT + 1) tick();
    @(negedge clk);
    chk("frames after close", 64'(frames_out[CW-1:0]), 64'(2));
    advance();

    // Open request mid-frame drains the whole frame, then drops.
    for (int k = 0; k < 5; k++) begin
      close_loop[0] = 1'b0;
      drive(0, 1'b1, k == 4, 32'hC0 + 32'(k));
      @(negedge clk);
      if (k == 1) chk("draining", 64'(loop_state[1:0]), 64'(DRAIN));
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, k == 2, 32'hE0 + 32'(k));
      @(negedge clk);
      if (k == 0) chk("open after drain", 64'(loop_state[1:0]), 64'(OPEN));
      advance();
    end
    idle();
    repeat (LAT + 1) tick();
    @(negedge clk);
    chk("frames after drain", 64'(frames_out[CW-1:0]), 64'(3));
    advance();

    // Channel 0 closed, channel 1 open, simultaneous frames.
    close_loop = 2'b01;
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, k == 2, 32'h100 + 32'(k));
      drive(1, 1'b1, k == 2, 32'h200 + 32'(k));
      tick();
    end
    idle();
    repeat (LAT + 1) tick();
    @(negedge clk);
    chk("open channel frames", 64'(frames_out[2*CW-1:CW]), 64'(0));
    chk("closed channel frames", 64'(frames_out[CW-1:0]), 64'(4));
    advance();

    // Async reset with beats in flight.
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'b0, 32'h300 + 32'(k));
      tick();
    end
    chk("pre-reset rx_tvalid", 64'(rx_tvalid[0]), 64'(1));
    #1 reset = 1'b1;
    #1;
    chk("async reset rx_tvalid", 64'(rx_tvalid), 64'(0));
    chk("async reset loop_state", 64'(loop_state), 64'(0));
    chk("async reset frames_out", 64'(frames_out), 64'(0));
    model_reset();
    idle();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (LAT + 3) tick();

    // 17 single-beat frames wrap a 4-bit counter to 1.
    for (int k = 0; k < 17; k++) begin
      drive(0, 1'b1, 1'b1, 32'h400 + 32'(k));
      tick();
    end
    idle();
    repeat (LAT + 1) tick();
    @(negedge clk);
    chk("counter wrap", 64'(frames_out[CW-1:0]), 64'(1));
    advance();

`ifdef AXIS_LOOPBACK_ERR_INJECT_EN
    inject_err[0] = 1'b1;
    tick();
    inject_err[0] = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h12345678);
    tick();
    drive(0, 1'b1, 1'b1, 32'h0000ABCD);
    tick();
    idle();
    repeat (LAT - 2) tick();
    @(negedge clk);
    chk("injected beat", 64'(rx_tdata[DW-1:0]), 64'(32'h12345679));
    advance();
    @(negedge clk);
    chk("beat after inject", 64'(rx_tdata[DW-1:0]), 64'(32'h0000ABCD));
    advance();
`endif

    // Randomized traffic and loop switching; a stretch toggles close_loop every cycle.
    rem[0] = 0;
    rem[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < NCHAN; ch++) begin
        if (c >= 600 && c < 700) close_loop[ch] = ~close_loop[ch];
        else if ($urandom_range(0, 19) == 0) close_loop[ch] = ~close_loop[ch];
        if (rem[ch] == 0 && $urandom_range(0, 3) != 0) rem[ch] = $urandom_range(1, 6);
        if (rem[ch] > 0) begin
          drive(ch, 1'b1, rem[ch] == 1, $urandom);
          rem[ch]--;
        end else begin
          drive(ch, 1'b0, 1'b0, 32'h0);
        end
`ifdef AXIS_LOOPBACK_ERR_INJECT_EN
        inject_err[ch] = ($urandom_range(0, 15) == 0);
`endif
      end
      tick();
    end
    idle();
    repeat (LAT + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
